// File: rtl/tx_burst_pkg.sv
// Shared types and helpers for the GMSK burst sequencer.
//   tx_state_t    : sequencer states PRIME -> ARMED -> BURST -> TAIL -> GUARD -> ARMED
//   IDLE_SYMBOL   : symbol fed to the modulator whenever no payload is active
//   sym_cnt_width : width of a counter that must hold 0..max_count
//   max_of4       : largest of four symbol counts, for sizing the shared counter
package tx_burst_pkg;

  typedef enum logic [2:0] {
    ST_PRIME = 3'd0,
    ST_ARMED = 3'd1,
    ST_BURST = 3'd2,
    ST_TAIL  = 3'd3,
    ST_GUARD = 3'd4
  } tx_state_t;

  localparam logic IDLE_SYMBOL = 1'b1;

  function automatic int unsigned sym_cnt_width(input int unsigned max_count);
    return (max_count == 0) ? 1 : unsigned'($clog2(max_count + 1));
  endfunction

  function automatic int unsigned max_of4(input int unsigned a, input int unsigned b,
                                          input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/tx_ramp_scaler.sv
// Power ramp for the RF output: arithmetic right shift of the I/Q samples by k.
// k loads RAMP_SHIFT on burst entry, walks down to 0 on each sample strobe while
// ramping down, and back up to RAMP_SHIFT while ramping up.
// Ports:
//   clock, reset_n           : clock, async active-low reset
//   ramp_load_i              : burst entry this cycle (forces k = RAMP_SHIFT)
//   ramp_down_i / ramp_up_i  : attenuation decreasing (BURST) / increasing (TAIL)
//   sample_strobe_i          : step enable for k
//   in_inphase_i/quadrature_i: unscaled samples
//   scaled_inphase_c/_quadrature_c : combinational scaled samples
module tx_ramp_scaler
  import tx_burst_pkg::*;
#(
  parameter int unsigned IQ_WIDTH   = 8,
  parameter int unsigned RAMP_SHIFT = 6
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       ramp_load_i,
  input  logic                       ramp_down_i,
  input  logic                       ramp_up_i,
  input  logic                       sample_strobe_i,
  input  logic signed [IQ_WIDTH-1:0] in_inphase_i,
  input  logic signed [IQ_WIDTH-1:0] in_quadrature_i,
  output logic signed [IQ_WIDTH-1:0] scaled_inphase_c,
  output logic signed [IQ_WIDTH-1:0] scaled_quadrature_c
);

  localparam int unsigned SHIFT_W = sym_cnt_width(RAMP_SHIFT);

  logic [SHIFT_W-1:0] k_q, k_d, k_eff_c;

  // Shift index stepping, saturating at both ends
  always_comb begin
    k_d = k_q;
    if (ramp_load_i) begin
      k_d = SHIFT_W'(RAMP_SHIFT);
    end else if (sample_strobe_i) begin
      if (ramp_down_i && (k_q != '0)) begin
        k_d = k_q - SHIFT_W'(1);
      end else if (ramp_up_i && (k_q != SHIFT_W'(RAMP_SHIFT))) begin
        k_d = k_q + SHIFT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      k_q <= '0;
    end else begin
      k_q <= k_d;
    end
  end

  // The first burst sample must already be fully attenuated
  assign k_eff_c             = ramp_load_i ? SHIFT_W'(RAMP_SHIFT) : k_q;
  assign scaled_inphase_c    = in_inphase_i >>> k_eff_c;
  assign scaled_quadrature_c = in_quadrature_i >>> k_eff_c;

endmodule

// File: rtl/tx_burst_sequencer.sv
// GMSK burst sequencer between the symbol source and the modulator/RF chain.
// Primes the modulator with idle symbols, arms, streams a fixed-length payload on
// fire_burst, then sends tail and guard periods before re-arming. Also produces
// the sample strobe and gates the I/Q path to the RF chain.
// Optional feature macro: TX_RAMP_EN (power ramp via tx_ramp_scaler).
// Ports:
//   clock, reset_n            : clock, async active-low reset
//   next_symbol_strobe        : modulator symbol request; boundary = its falling edge
//   current_symbol            : symbol to the modulator
//   sample_strobe             : one-cycle pulse every CLOCKS_PER_SAMPLE cycles
//   fire_burst / is_armed     : burst request / ready to fire
//   busy                      : in BURST, TAIL or GUARD
//   sym_data/sym_valid/sym_ready, underrun : payload handshake and starvation flag
//   modulator_*/rfchain_*     : signed I/Q in / gated I/Q out, iq_valid marks live samples
module tx_burst_sequencer
  import tx_burst_pkg::*;
#(
  parameter int unsigned IQ_WIDTH          = 8,
  parameter int unsigned CLOCKS_PER_SAMPLE = 4,
  parameter int unsigned PRIME_SYMBOLS     = 4,
  parameter int unsigned BURST_SYMBOLS     = 148,
  parameter int unsigned TAIL_SYMBOLS      = 3,
  parameter int unsigned GUARD_SYMBOLS     = 8,
  parameter int unsigned RAMP_SHIFT        = 6
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       next_symbol_strobe,
  output logic                       current_symbol,
  output logic                       sample_strobe,
  input  logic                       fire_burst,
  output logic                       is_armed,
  output logic                       busy,
  input  logic                       sym_data,
  input  logic                       sym_valid,
  output logic                       sym_ready,
  output logic                       underrun,
  input  logic signed [IQ_WIDTH-1:0] modulator_inphase,
  input  logic signed [IQ_WIDTH-1:0] modulator_quadrature,
  output logic signed [IQ_WIDTH-1:0] rfchain_inphase,
  output logic signed [IQ_WIDTH-1:0] rfchain_quadrature,
  output logic                       iq_valid
);

  localparam int unsigned MAX_SYMS = max_of4(PRIME_SYMBOLS, BURST_SYMBOLS,
                                             TAIL_SYMBOLS, GUARD_SYMBOLS);
  localparam int unsigned CNT_W    = sym_cnt_width(MAX_SYMS);
  localparam int unsigned DIV_W    = sym_cnt_width(CLOCKS_PER_SAMPLE - 1);

  if (CLOCKS_PER_SAMPLE < 2) begin : g_bad_cps
    $error("CLOCKS_PER_SAMPLE must be at least 2");
  end
  if (RAMP_SHIFT > IQ_WIDTH - 1) begin : g_bad_ramp
    $error("RAMP_SHIFT must not exceed IQ_WIDTH-1");
  end

  tx_state_t               state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    fire_q, fire_d;
  logic                    nss_q;
  logic [DIV_W-1:0]        div_q, div_d;
  logic                    strobe_q;
  logic                    cur_sym_q, cur_sym_d;
  logic                    ready_q, ready_d;
  logic                    under_q, under_d;
  logic                    armed_q, busy_q, live_q, live_d;
  logic signed [IQ_WIDTH-1:0] rf_inph_q, rf_quad_q, scaled_inph_c, scaled_quad_c;
  logic                    boundary_c;

  assign boundary_c = nss_q & ~next_symbol_strobe;

  // Next state, shared boundary counter and fire latch
  always_comb begin
    state_d = state_q;
    fire_d  = 1'b0;
    cnt_d   = cnt_q;
    if (boundary_c && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    case (state_q)
      ST_PRIME: if (boundary_c && (cnt_q == CNT_W'(PRIME_SYMBOLS - 1))) state_d = ST_ARMED;
      ST_ARMED: begin
        // A fire coincident with a boundary launches at that boundary
        fire_d = fire_q | fire_burst;
        if (boundary_c && fire_d) state_d = ST_BURST;
      end
      ST_BURST: if (boundary_c && (cnt_q == CNT_W'(BURST_SYMBOLS - 1))) state_d = ST_TAIL;
      ST_TAIL:  if (boundary_c && (cnt_q == CNT_W'(TAIL_SYMBOLS - 1)))  state_d = ST_GUARD;
      ST_GUARD: if (boundary_c && (cnt_q == CNT_W'(GUARD_SYMBOLS - 1))) state_d = ST_ARMED;
      default:  state_d = ST_PRIME;
    endcase
    if (state_d != state_q) begin
      cnt_d  = '0;
      fire_d = 1'b0;
    end
  end

  // Symbol path, handshake and sample divider
  always_comb begin
    ready_d   = boundary_c && (state_q == ST_BURST);
    under_d   = ready_d && !sym_valid;
    cur_sym_d = IDLE_SYMBOL;
    case (state_q)
      // BURST/TAIL only change at boundaries so the last payload bit holds a full symbol
      ST_BURST: cur_sym_d = !boundary_c ? cur_sym_q : (sym_valid ? sym_data : IDLE_SYMBOL);
      ST_TAIL:  cur_sym_d = boundary_c ? IDLE_SYMBOL : cur_sym_q;
      default:  cur_sym_d = IDLE_SYMBOL;
    endcase
    live_d = (state_d == ST_BURST) || (state_d == ST_TAIL);
    div_d  = (div_q == DIV_W'(CLOCKS_PER_SAMPLE - 1)) ? '0 : div_q + DIV_W'(1);
  end

`ifdef TX_RAMP_EN
  logic ramp_load_c;
  assign ramp_load_c = (state_d == ST_BURST) && (state_q != ST_BURST);

  tx_ramp_scaler #(
    .IQ_WIDTH   (IQ_WIDTH),
    .RAMP_SHIFT (RAMP_SHIFT)
  ) u_ramp (
    .clock               (clock),
    .reset_n             (reset_n),
    .ramp_load_i         (ramp_load_c),
    .ramp_down_i         (state_q == ST_BURST),
    .ramp_up_i           (state_q == ST_TAIL),
    .sample_strobe_i     (strobe_q),
    .in_inphase_i        (modulator_inphase),
    .in_quadrature_i     (modulator_quadrature),
    .scaled_inphase_c    (scaled_inph_c),
    .scaled_quadrature_c (scaled_quad_c)
  );
`else
  assign scaled_inph_c = modulator_inphase;
  assign scaled_quad_c = modulator_quadrature;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_PRIME;
      cnt_q     <= '0;
      fire_q    <= 1'b0;
      nss_q     <= 1'b0;
      div_q     <= '0;
      strobe_q  <= 1'b0;
      cur_sym_q <= 1'b0;
      ready_q   <= 1'b0;
      under_q   <= 1'b0;
      armed_q   <= 1'b0;
      busy_q    <= 1'b0;
      live_q    <= 1'b0;
      rf_inph_q <= '0;
      rf_quad_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fire_q    <= fire_d;
      nss_q     <= next_symbol_strobe;
      div_q     <= div_d;
      strobe_q  <= (div_q == '0);
      cur_sym_q <= cur_sym_d;
      ready_q   <= ready_d;
      under_q   <= under_d;
      armed_q   <= (state_d == ST_ARMED);
      busy_q    <= (state_d == ST_BURST) || (state_d == ST_TAIL) || (state_d == ST_GUARD);
      live_q    <= live_d;
      rf_inph_q <= live_d ? scaled_inph_c : '0;
      rf_quad_q <= live_d ? scaled_quad_c : '0;
    end
  end

  assign current_symbol     = cur_sym_q;
  assign sample_strobe      = strobe_q;
  assign is_armed           = armed_q;
  assign busy               = busy_q;
  assign sym_ready          = ready_q;
  assign underrun           = under_q;
  assign rfchain_inphase    = rf_inph_q;
  assign rfchain_quadrature = rf_quad_q;
  assign iq_valid           = live_q;

endmodule
